// File: rtl/event_drain_master_pkg.sv
// Shared definitions for the event drain master: STATUS bit layout,
// default monitor register map and the drain FSM state encoding.
package event_drain_pkg;

    localparam int STATUS_TRIG_BIT  = 0;
    localparam int STATUS_OVF_BIT   = 1;
    localparam int STATUS_EMPTY_BIT = 2;

    localparam logic [7:0] DEF_ADDR_STATUS   = 8'h0C;
    localparam logic [7:0] DEF_ADDR_EVT_ID   = 8'h10;
    localparam logic [7:0] DEF_ADDR_EVT_TS   = 8'h14;
    localparam logic [7:0] DEF_ADDR_EVT_DATA = 8'h18;
    localparam logic [7:0] DEF_ADDR_EVT_POP  = 8'h1C;

    typedef logic [3:0] drain_state_t;

    localparam drain_state_t ST_IDLE      = 4'd0;
    localparam drain_state_t ST_POLL      = 4'd1;
    localparam drain_state_t ST_POLL_W    = 4'd2;
    localparam drain_state_t ST_GAP       = 4'd3;
    localparam drain_state_t ST_RD_ID     = 4'd4;
    localparam drain_state_t ST_RD_ID_W   = 4'd5;
    localparam drain_state_t ST_RD_TS     = 4'd6;
    localparam drain_state_t ST_RD_TS_W   = 4'd7;
    localparam drain_state_t ST_RD_DATA   = 4'd8;
    localparam drain_state_t ST_RD_DATA_W = 4'd9;
    localparam drain_state_t ST_POP       = 4'd10;
    localparam drain_state_t ST_OUT       = 4'd11;

    // States that drive a read strobe; the following state captures rdata.
    function automatic logic is_rd_state(input drain_state_t s);
        return (s == ST_POLL) || (s == ST_RD_ID) || (s == ST_RD_TS) || (s == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/event_drain_master_if.sv
// Bus and event-stream bundle between the drain master, the monitor's
// register port and the downstream event consumer.
interface event_drain_master_if #(
    parameter int ID_W    = 8,
    parameter int TS_W    = 32,
    parameter int PROBE_W = 32
);
    import event_drain_pkg::*;

    logic               bus_wr;
    logic               bus_rd;
    logic [7:0]         bus_addr;
    logic [31:0]        bus_wdata;
    logic [31:0]        bus_rdata;

    logic               ev_valid;
    logic               ev_ready;
    logic [ID_W-1:0]    ev_id;
    logic [TS_W-1:0]    ev_ts;
    logic [PROBE_W-1:0] ev_data;

    modport master (
        output bus_wr, bus_rd, bus_addr, bus_wdata,
        input  bus_rdata,
        output ev_valid, ev_id, ev_ts, ev_data,
        input  ev_ready
    );

    modport slave (
        input  bus_wr, bus_rd, bus_addr, bus_wdata,
        output bus_rdata,
        input  ev_valid, ev_id, ev_ts, ev_data,
        output ev_ready
    );

endinterface

// File: rtl/event_drain_master.sv
// Polls the event monitor STATUS register, reads and pops each head record
// and hands it to a valid/ready stream consumer.
//
// state        | meaning
// -------------+-------------------------------------------------------
// IDLE         | waiting for en
// POLL         | read strobe to STATUS
// POLL_W       | capture STATUS, decide: fetch record / gap / idle
// GAP          | idle POLL_GAP cycles between empty polls
// RD_ID(_W)    | read strobe / capture of head event ID
// RD_TS(_W)    | read strobe / capture of head timestamp
// RD_DATA(_W)  | read strobe / capture of head probe data
// POP          | write strobe to POP register
// OUT          | record presented on the stream until ev_ready
module event_drain_master
    import event_drain_pkg::*;
#(
    parameter int         ID_W          = 8,
    parameter int         TS_W          = 32,
    parameter int         PROBE_W       = 32,
    parameter int         POLL_GAP      = 4,
    parameter logic [7:0] ADDR_STATUS   = DEF_ADDR_STATUS,
    parameter logic [7:0] ADDR_EVT_ID   = DEF_ADDR_EVT_ID,
    parameter logic [7:0] ADDR_EVT_TS   = DEF_ADDR_EVT_TS,
    parameter logic [7:0] ADDR_EVT_DATA = DEF_ADDR_EVT_DATA,
    parameter logic [7:0] ADDR_EVT_POP  = DEF_ADDR_EVT_POP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    event_drain_master_if.master  drain,
    output logic                  ovf_seen,
    input  logic                  ovf_clr,
    output logic [15:0]           ev_count
);

    localparam logic [15:0] GAP_LOAD = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

    drain_state_t state;
    drain_state_t state_nxt;
    logic [15:0]  gap_cnt;
    logic         status_empty;
    logic         status_ovf;
    logic         handshake;

    function automatic logic [7:0] rd_addr(input drain_state_t s);
        case (s)
            ST_POLL:    rd_addr = ADDR_STATUS;
            ST_RD_ID:   rd_addr = ADDR_EVT_ID;
            ST_RD_TS:   rd_addr = ADDR_EVT_TS;
            ST_RD_DATA: rd_addr = ADDR_EVT_DATA;
            default:    rd_addr = 8'h00;
        endcase
    endfunction

    // Address/data are forced to zero whenever no strobe is driven.
    assign drain.bus_rd    = is_rd_state(state);
    assign drain.bus_wr    = (state == ST_POP);
    assign drain.bus_addr  = (state == ST_POP) ? ADDR_EVT_POP : rd_addr(state);
    assign drain.bus_wdata = (state == ST_POP) ? 32'h0000_0001 : 32'h0000_0000;
    assign drain.ev_valid  = (state == ST_OUT);

    assign status_empty = drain.bus_rdata[STATUS_EMPTY_BIT];
    assign status_ovf   = drain.bus_rdata[STATUS_OVF_BIT];
    assign handshake    = (state == ST_OUT) && drain.ev_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (en) state_nxt = ST_POLL;
            ST_POLL:      state_nxt = ST_POLL_W;
            ST_POLL_W: begin
                if (!status_empty)     state_nxt = ST_RD_ID;
                else if (!en)          state_nxt = ST_IDLE;
                else if (POLL_GAP > 0) state_nxt = ST_GAP;
                else                   state_nxt = ST_POLL;
            end
            ST_GAP: begin
                if (!en)               state_nxt = ST_IDLE;
                else if (gap_cnt == 0) state_nxt = ST_POLL;
            end
            ST_RD_ID:     state_nxt = ST_RD_ID_W;
            ST_RD_ID_W:   state_nxt = ST_RD_TS;
            ST_RD_TS:     state_nxt = ST_RD_TS_W;
            ST_RD_TS_W:   state_nxt = ST_RD_DATA;
            ST_RD_DATA:   state_nxt = ST_RD_DATA_W;
            ST_RD_DATA_W: state_nxt = ST_POP;
            ST_POP:       state_nxt = ST_OUT;
            // Once a record is popped it is always delivered, whatever en does.
            ST_OUT:       if (drain.ev_ready) state_nxt = en ? ST_POLL : ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= 16'd0;
        end else if (state == ST_IDLE) begin
            gap_cnt <= 16'd0;
        end else if (state == ST_POLL_W) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == ST_GAP) && (gap_cnt != 16'd0)) begin
            gap_cnt <= gap_cnt - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain.ev_id   <= '0;
            drain.ev_ts   <= '0;
            drain.ev_data <= '0;
        end else begin
            case (state)
                ST_RD_ID_W:   drain.ev_id   <= drain.bus_rdata[ID_W-1:0];
                ST_RD_TS_W:   drain.ev_ts   <= drain.bus_rdata[TS_W-1:0];
                ST_RD_DATA_W: drain.ev_data <= drain.bus_rdata[PROBE_W-1:0];
                default: ;
            endcase
        end
    end

    // A fresh overflow observation beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_seen <= 1'b0;
        end else if ((state == ST_POLL_W) && status_ovf) begin
            ovf_seen <= 1'b1;
        end else if (ovf_clr) begin
            ovf_seen <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_count <= 16'd0;
        end else if (handshake) begin
            ev_count <= ev_count + 16'd1;
        end
    end

    a_one_strobe: assert property (@(posedge clk) disable iff (rst)
        !(drain.bus_wr && drain.bus_rd));

    a_single_cycle_strobe: assert property (@(posedge clk) disable iff (rst)
        (drain.bus_wr || drain.bus_rd) |=> !(drain.bus_wr || drain.bus_rd));

endmodule

// File: tb/tb_event_drain_master.sv
// Self-checking bench: behavioural event monitor on the bus side, a
// record-order scoreboard on the stream side, directed corners and random traffic.
module tb_event_drain_master;
    import event_drain_pkg::*;

    localparam int FIFO_DEPTH = 16;
    localparam int POLL_GAP   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ovf_clr;
    logic        ovf_seen;
    logic [15:0] ev_count;

    event_drain_master_if #(.ID_W(8), .TS_W(32), .PROBE_W(32)) bif ();

    event_drain_master #(.ID_W(8), .TS_W(32), .PROBE_W(32), .POLL_GAP(POLL_GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .drain    (bif),
        .ovf_seen (ovf_seen),
        .ovf_clr  (ovf_clr),
        .ev_count (ev_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] ts;
        logic [31:0] data;
    } rec_t;

    typedef struct {
        int          n_push;
        bit          mon_ovf;
        logic [28:0] junk;
        int          exp_deliv;
        bit          exp_ovf;
    } vec_t;

    rec_t        mon_q[$];
    rec_t        exp_q[$];
    rec_t        e_chk;
    bit          mon_ovf;
    bit          mon_trig;
    logic [28:0] status_junk;

    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    int  viol = 0;
    bit  checking = 0;
    int  n_pop = 0, n_deliv = 0, n_status_rd = 0, n_evt_rd = 0;
    int  last_ne_cyc = 0, last_lat = 0;
    bit  gap_track = 0, saw_ts_rd = 0, saw_data_rd = 0;
    int  status_cycs[$];
    bit  ovf_exp = 0, status_pending = 0;
    logic [15:0] cnt_exp = 16'd0;
    logic        prev_valid = 0, prev_hs = 0, prev_rst = 0, prev_strobe = 0, hs, strobe;
    logic [7:0]  prev_id;
    logic [31:0] prev_ts, prev_data;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void proto_fail(input string what);
        viol++;
        if (viol <= 20) $display("FAIL proto_%s: violation observed at cycle %0d, expected none", what, cyc);
    endfunction

    // Behavioural monitor register port: rdata registered one cycle after bus_rd.
    always @(posedge clk) begin
        cyc++;
        if (rst) ovf_exp = 1'b0;
        else if (status_pending && bif.bus_rdata[STATUS_OVF_BIT]) ovf_exp = 1'b1;
        else if (ovf_clr) ovf_exp = 1'b0;
        status_pending = (bif.bus_rd === 1'b1) && (bif.bus_addr == DEF_ADDR_STATUS) && !rst;
        if (bif.bus_rd === 1'b1) begin
            case (bif.bus_addr)
                DEF_ADDR_STATUS:   bif.bus_rdata <= {status_junk, mon_q.size() == 0, mon_ovf, mon_trig};
                DEF_ADDR_EVT_ID:   bif.bus_rdata <= (mon_q.size() != 0) ? {24'hA5A5A5, mon_q[0].id} : 32'h0;
                DEF_ADDR_EVT_TS:   bif.bus_rdata <= (mon_q.size() != 0) ? mon_q[0].ts : 32'h0;
                DEF_ADDR_EVT_DATA: bif.bus_rdata <= (mon_q.size() != 0) ? mon_q[0].data : 32'h0;
                default:           bif.bus_rdata <= 32'hBAD0_0000;
            endcase
        end else begin
            bif.bus_rdata <= $urandom;
        end
        if ((bif.bus_wr === 1'b1) && (bif.bus_addr == DEF_ADDR_EVT_POP) && (mon_q.size() != 0))
            void'(mon_q.pop_front());
    end

    // Protocol observer and record scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (checking) begin
            strobe = bif.bus_wr | bif.bus_rd;
            if (bif.bus_wr && bif.bus_rd) proto_fail("wr_and_rd");
            if (!strobe && (bif.bus_addr != 8'h0 || bif.bus_wdata != 32'h0)) proto_fail("idle_bus_nonzero");
            if (strobe && prev_strobe) proto_fail("strobe_two_cycles");
            if (bif.bus_wr && (bif.bus_addr != DEF_ADDR_EVT_POP || bif.bus_wdata != 32'h1)) proto_fail("pop_write");
            if (bif.bus_rd && bif.bus_wdata != 32'h0) proto_fail("rd_wdata");
            if (bif.ev_valid && strobe) proto_fail("bus_during_out");
            if (prev_valid && !prev_hs && !prev_rst &&
                (!bif.ev_valid || bif.ev_id != prev_id || bif.ev_ts != prev_ts || bif.ev_data != prev_data))
                proto_fail("record_not_held");
            if (ovf_seen !== ovf_exp) proto_fail("ovf_seen");
            if (ev_count !== cnt_exp) proto_fail("ev_count");
            if (bif.bus_rd && bif.bus_addr == DEF_ADDR_STATUS) begin
                n_status_rd++;
                if (gap_track) status_cycs.push_back(cyc);
                if (mon_q.size() != 0) last_ne_cyc = cyc;
            end
            if (bif.bus_rd && bif.bus_addr inside {DEF_ADDR_EVT_ID, DEF_ADDR_EVT_TS, DEF_ADDR_EVT_DATA}) n_evt_rd++;
            if (bif.bus_rd && bif.bus_addr == DEF_ADDR_EVT_TS) saw_ts_rd = 1;
            if (bif.bus_rd && bif.bus_addr == DEF_ADDR_EVT_DATA) saw_data_rd = 1;
            if (bif.bus_wr) n_pop++;
            if (bif.ev_valid && !prev_valid) last_lat = cyc - last_ne_cyc;
            hs = bif.ev_valid && bif.ev_ready && !rst;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    proto_fail("unexpected_record");
                end else begin
                    e_chk = exp_q.pop_front();
                    check("ev_id", bif.ev_id, e_chk.id);
                    check("ev_ts", bif.ev_ts, e_chk.ts);
                    check("ev_data", bif.ev_data, e_chk.data);
                    check("pop_before_out", n_pop, n_deliv + 1);
                end
                n_deliv++;
                cnt_exp = cnt_exp + 16'd1;
            end
            if (rst) cnt_exp = 16'd0;
            prev_valid  = bif.ev_valid;
            prev_hs     = hs;
            prev_rst    = rst;
            prev_strobe = strobe;
            prev_id     = bif.ev_id;
            prev_ts     = bif.ev_ts;
            prev_data   = bif.ev_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input logic [7:0] id, input logic [31:0] data);
        rec_t r;
        r.id   = id;
        r.ts   = 32'(cyc);
        r.data = data;
        mon_trig = 1'b1;
        if (mon_q.size() < FIFO_DEPTH) begin
            mon_q.push_back(r);
            exp_q.push_back(r);
        end else begin
            mon_ovf = 1'b1;
        end
    endtask

    task automatic wait_deliv(input int target, input int budget, input string name);
        int k = 0;
        while (n_deliv < target && k < budget) begin
            tick();
            k++;
        end
        check(name, n_deliv, target);
    endtask

    vec_t vecs[6];

    initial begin
        int base, p0, s0, k;
        vecs[0] = '{1,  1'b0, 29'h0,         1,  1'b0};
        vecs[1] = '{3,  1'b0, 29'h1FFF_FFFF, 3,  1'b0};
        vecs[2] = '{22, 1'b0, 29'h0,         16, 1'b1};
        vecs[3] = '{2,  1'b0, 29'h0AAA_5555, 2,  1'b0};
        vecs[4] = '{0,  1'b1, 29'h0,         0,  1'b1};
        vecs[5] = '{5,  1'b0, 29'h1555_0F0F, 5,  1'b0};

        rst = 1'b1; en = 1'b0; ovf_clr = 1'b0; bif.ev_ready = 1'b0;
        mon_ovf = 1'b0; mon_trig = 1'b0; status_junk = '0;
        repeat (3) tick();
        check("rst_bus", {bif.bus_wr, bif.bus_rd, bif.bus_addr, bif.bus_wdata}, 0);
        check("rst_ev_valid", bif.ev_valid, 0);
        check("rst_ovf_seen", ovf_seen, 0);
        check("rst_ev_count", ev_count, 0);
        rst = 1'b0;
        checking = 1'b1;

        // Empty FIFO: STATUS polled every POLL_GAP+2 cycles, nothing else.
        gap_track = 1'b1;
        en = 1'b1;
        k = 0;
        while (status_cycs.size() < 5 && k < 100) begin tick(); k++; end
        check("poll_seen", status_cycs.size() >= 5, 1);
        for (int i = 1; i < status_cycs.size() && i < 5; i++)
            check("poll_interval", status_cycs[i] - status_cycs[i-1], POLL_GAP + 2);
        gap_track = 1'b0;
        check("empty_no_evt_reads", n_evt_rd, 0);
        check("empty_no_valid", n_deliv, 0);

        // Single record with fixed payload; latency from non-empty STATUS strobe.
        bif.ev_ready = 1'b1;
        p0 = n_pop;
        push_rec(8'h5A, 32'h0000_1234);
        wait_deliv(1, 100, "single_deliv");
        tick();
        check("single_latency", last_lat, 9);
        check("single_pops", n_pop - p0, 1);
        check("single_ev_count", ev_count, 1);

        // Three records held back by ev_ready.
        bif.ev_ready = 1'b0;
        base = n_deliv;
        for (int i = 0; i < 3; i++) begin
            push_rec(8'($urandom), $urandom);
            tick();
        end
        k = 0;
        while (!bif.ev_valid && k < 100) begin tick(); k++; end
        check("hold_valid_rise", bif.ev_valid, 1);
        s0 = n_status_rd + n_evt_rd + n_pop;
        repeat (10) tick();
        check("hold_valid_kept", bif.ev_valid, 1);
        check("hold_no_strobes", n_status_rd + n_evt_rd + n_pop - s0, 0);
        bif.ev_ready = 1'b1;
        wait_deliv(base + 3, 200, "hold_deliv");
        tick();
        check("hold_ev_count", ev_count, 4);

        // en dropped mid-record: record still completes, then idle.
        saw_ts_rd = 1'b0;
        p0 = n_pop;
        base = n_deliv;
        push_rec(8'hC3, $urandom);
        k = 0;
        while (!saw_ts_rd && k < 100) begin tick(); k++; end
        en = 1'b0;
        wait_deliv(base + 1, 50, "endrop_deliv");
        check("endrop_pop", n_pop - p0, 1);
        s0 = n_status_rd;
        repeat (20) tick();
        check("endrop_no_polls", n_status_rd - s0, 0);
        check("endrop_valid_low", bif.ev_valid, 0);

        // Reset while waiting for the data word: no pop, record survives.
        en = 1'b1;
        saw_data_rd = 1'b0;
        push_rec(8'h3C, $urandom);
        k = 0;
        while (!saw_data_rd && k < 100) begin tick(); k++; end
        rst = 1'b1;
        en = 1'b0;
        p0 = n_pop;
        tick();
        check("rstmid_bus", {bif.bus_wr, bif.bus_rd, bif.bus_addr, bif.bus_wdata}, 0);
        check("rstmid_valid", bif.ev_valid, 0);
        check("rstmid_count", ev_count, 0);
        rst = 1'b0;
        repeat (5) tick();
        check("rstmid_no_pop", n_pop - p0, 0);
        check("rstmid_fifo_kept", mon_q.size(), 1);
        base = n_deliv;
        en = 1'b1;
        wait_deliv(base + 1, 100, "rstmid_deliv");
        tick();
        check("rstmid_ev_count", ev_count, 1);

        // Table-driven batches loaded while idle, then drained.
        foreach (vecs[v]) begin
            en = 1'b0;
            bif.ev_ready = 1'b1;
            repeat (20) tick();
            mon_ovf = vecs[v].mon_ovf;
            status_junk = vecs[v].junk;
            ovf_clr = 1'b1;
            tick();
            ovf_clr = 1'b0;
            check("vec_ovf_clr", ovf_seen, 0);
            base = n_deliv;
            for (int i = 0; i < vecs[v].n_push; i++) begin
                push_rec(8'($urandom), $urandom);
                tick();
            end
            en = 1'b1;
            wait_deliv(base + vecs[v].exp_deliv, 600, "vec_deliv");
            repeat (20) tick();
            check("vec_deliv_exact", n_deliv - base, vecs[v].exp_deliv);
            check("vec_ovf_seen", ovf_seen, vecs[v].exp_ovf);
            check("vec_exp_empty", exp_q.size(), 0);
        end
        mon_ovf = 1'b0;
        status_junk = '0;

        // Random traffic against the scoreboard.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) push_rec(8'($urandom), $urandom);
            bif.ev_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 49) == 0) en = ~en;
            ovf_clr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) mon_ovf = 1'b0;
            tick();
        end
        en = 1'b1;
        bif.ev_ready = 1'b1;
        ovf_clr = 1'b0;
        k = 0;
        while ((exp_q.size() != 0 || mon_q.size() != 0) && k < 1500) begin tick(); k++; end
        repeat (5) tick();
        check("rand_drained", exp_q.size(), 0);
        check("rand_ev_count", ev_count, cnt_exp);
        check("protocol_violations", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
